fifo_sync_prog: RTL

Parametrised successor to fifo_sync. Single-clock FIFO with configurable data width and depth (power of two). Adds programmable almost-full and almost-empty flags, sticky overflow/underflow error flags, and a compile-time selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer stages in the same clock domain.

---
 rtl/fifo_sync_prog.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with programmable almost-full / almost-empty
// flags, sticky overflow / underflow error flags and a compile-time selectable
// read mode (FWFT=0: registered read with one cycle of latency, FWFT=1:
// first-word-fall-through from an asynchronous-read memory).
//
// Optional feature: define FIFO_PEAK_FILL_EN to add o_peak_fill, a registered
// high-water mark of the fill level. Without the macro the port and its logic
// are absent and everything else behaves identically.

module fifo_sync_prog #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned FWFT   = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_fill,
    input  logic [ADDR_W:0]   i_afull_th,
    input  logic [ADDR_W:0]   i_aempty_th,
    output logic              o_afull,
    output logic              o_aempty,
    input  logic              i_clr_err,
    output logic              o_overflow,
    output logic              o_underflow
`ifdef FIFO_PEAK_FILL_EN
    ,
    output logic [ADDR_W:0]   o_peak_fill
`endif
);

    // Fill value of a completely full FIFO (DEPTH = 2**ADDR_W).
    localparam logic [ADDR_W:0] FillMax = {1'b1, {ADDR_W{1'b0}}};

    // Storage: not reset, contents are only ever read at valid pointer positions.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    // Status decode and request qualification from the registered fill level.
    always_comb begin
        full  = (fill_q == FillMax);
        empty = (fill_q == '0);
        wr_en = i_wr & ~full;
        rd_en = i_rd & ~empty;
    end

    // Next-state for pointers, fill level and sticky error flags.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;

        // Power-of-two depth: pointers wrap naturally with no gap.
        if (wr_en) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   fill_d = fill_q + (ADDR_W + 1)'(1);
            2'b01:   fill_d = fill_q - (ADDR_W + 1)'(1);
            default: fill_d = fill_q;
        endcase

        // Clear first, then set: a set in the same cycle as a clear wins.
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (i_wr && full) begin
            overflow_d = 1'b1;
        end
        if (i_rd && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port; a write in a reset cycle is not accepted.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            mem[wptr_q] <= i_data;
        end
    end

    // Registered status and error outputs, thresholds compared unsigned.
    always_comb begin
        o_fill      = fill_q;
        o_full      = full;
        o_empty     = empty;
        o_afull     = (fill_q >= i_afull_th);
        o_aempty    = (fill_q <= i_aempty_th);
        o_overflow  = overflow_q;
        o_underflow = underflow_q;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is always presented; zero while there is no head so the
        // output is defined out of reset without clearing memory.
        always_comb begin
            o_valid = ~empty;
            o_data  = empty ? '0 : mem[rptr_q];
        end
    end else begin : g_std
        logic [DATA_W-1:0] data_q;
        logic              valid_q;

        // Registered read: data appears the cycle after the accepted read.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_en;
                if (rd_en) begin
                    data_q <= mem[rptr_q];
                end
            end
        end

        // Drive read outputs from the read register.
        always_comb begin
            o_valid = valid_q;
            o_data  = data_q;
        end
    end

`ifdef FIFO_PEAK_FILL_EN
    logic [ADDR_W:0] peak_q, peak_d;

    // High-water mark of the next fill; a clear restarts it from the current fill.
    always_comb begin
        peak_d = peak_q;
        if (i_clr_err) begin
            peak_d = fill_q;
        end else if (fill_d > peak_q) begin
            peak_d = fill_d;
        end
    end

    // Peak register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    // Expose the high-water mark.
    always_comb begin
        o_peak_fill = peak_q;
    end
`endif

endmodule
